mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port with anti-starvation for fetch.
// Optional abort watchdog compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_sign_i,
  output logic        d_gnt_o,
  output logic        d_valid_o,
  output logic [31:0] d_rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [1:0]  m_size_o,
  output logic        m_sign_o,
  input  logic        m_rdy_i,
  input  logic [31:0] m_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [1:0]          m_size_q, m_size_d;
  logic                m_sign_q, m_sign_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                starve_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int WaitW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic             timeout_hit;
  assign timeout_hit = (wait_q == WaitW'(TIMEOUT_CYC - 1));
`endif

  // Fetch overrides data once it has been passed over STARVE_MAX times in a row.
  assign starve_hit = if_req_i && (starve_q == StarveW'(STARVE_MAX));

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_size_d   = m_size_q;
    m_sign_d   = m_sign_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt_o   = 1'b0;
    d_gnt_o    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_d     = wait_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_req_i && !starve_hit) begin
          d_gnt_o   = 1'b1;
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we_i;
          m_addr_d  = d_addr_i;
          m_wdata_d = d_wdata_i;
          m_size_d  = d_size_i;
          m_sign_d  = d_sign_i;
          if (if_req_i && (starve_q != StarveW'(STARVE_MAX)))
            starve_d = starve_q + StarveW'(1);
`ifdef ARB_TIMEOUT_EN
          wait_d = '0;
`endif
        end else if (if_req_i) begin
          if_gnt_o  = 1'b1;
          state_d   = BUSY_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr_i;
          m_wdata_d = 32'h0;
          m_size_d  = 2'b10;
          m_sign_d  = 1'b0;
          starve_d  = '0;
`ifdef ARB_TIMEOUT_EN
          wait_d = '0;
`endif
        end
      end
      BUSY_IF, BUSY_D: begin
        // Only reads update the owner's data register; writes just pulse VALID.
        if (m_rdy_i) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if (!m_we_q) if_rdata_d = m_rdata_i;
          end else begin
            d_valid_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata_i;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (state_q == BUSY_IF) if_valid_d = 1'b1;
          else                    d_valid_d  = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= 32'h0;
      m_wdata_q  <= 32'h0;
      m_size_q   <= 2'b00;
      m_sign_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_size_q   <= m_size_d;
      m_sign_q   <= m_sign_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign m_size_o   = m_size_q;
  assign m_sign_o   = m_sign_q;
  assign if_valid_o = if_valid_q;
  assign d_valid_o  = d_valid_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        ifReq, dReq, dWe, dSign, mRdy;
  logic [31:0] ifAddr, dAddr, dWdata, mRdata;
  logic [1:0]  dSize;
  logic        ifGnt, ifValid, dGnt, dValid, mReq, mWe, mSign, busy, err;
  logic [31:0] ifRdata, dRdata, mAddr, mWdata;
  logic [1:0]  mSize;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT_CYC(TCYC)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt), .if_valid_o(ifValid), .if_rdata_o(ifRdata),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_size_i(dSize), .d_sign_i(dSign),
    .d_gnt_o(dGnt), .d_valid_o(dValid), .d_rdata_o(dRdata),
    .m_req_o(mReq), .m_we_o(mWe), .m_addr_o(mAddr), .m_wdata_o(mWdata), .m_size_o(mSize), .m_sign_o(mSign),
    .m_rdy_i(mRdy), .m_rdata_i(mRdata), .busy_o(busy), .err_o(err)
  );

  task applyStimulus;
    ifReq = 0; ifAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWdata = 0;
    dSize = 0; dSign = 0; mRdy = 0; mRdata = 0;
  endtask

  task nextCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task doReset;
    rstN = 0;
    applyStimulus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1;
  endtask

  task test_reset;
    doReset();
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset.busy got %0h want 0", busy); end
    checks++; if (mReq !== 1'b0)     begin errors++; $display("[TB] FAIL reset.mReq got %0h want 0", mReq); end
    checks++; if (mWe !== 1'b0)      begin errors++; $display("[TB] FAIL reset.mWe got %0h want 0", mWe); end
    checks++; if (mAddr !== 32'h0)   begin errors++; $display("[TB] FAIL reset.mAddr got %0h want 0", mAddr); end
    checks++; if (ifValid !== 1'b0 || dValid !== 1'b0) begin errors++; $display("[TB] FAIL reset.valid got %0h/%0h want 0/0", ifValid, dValid); end
    checks++; if (ifRdata !== 32'h0 || dRdata !== 32'h0) begin errors++; $display("[TB] FAIL reset.rdata got %0h/%0h want 0/0", ifRdata, dRdata); end
    checks++; if (err !== 1'b0)      begin errors++; $display("[TB] FAIL reset.err got %0h want 0", err); end
    checks++; if (ifGnt !== 1'b0 || dGnt !== 1'b0) begin errors++; $display("[TB] FAIL reset.gnt got %0h/%0h want 0/0", ifGnt, dGnt); end
  endtask

  task test_fetch_read;
    doReset();
    ifReq = 1; ifAddr = 32'h100;
    #1;
    checks++; if (ifGnt !== 1'b1 || dGnt !== 1'b0) begin errors++; $display("[TB] FAIL fetch.gnt got %0h/%0h want 1/0", ifGnt, dGnt); end
    nextCycle();
    ifReq = 0; mRdy = 1; mRdata = 32'h13;
    #1;
    checks++; if (mReq !== 1'b1)      begin errors++; $display("[TB] FAIL fetch.mReq got %0h want 1", mReq); end
    checks++; if (mAddr !== 32'h100)  begin errors++; $display("[TB] FAIL fetch.mAddr got %0h want 100", mAddr); end
    checks++; if (mWe !== 1'b0 || mSize !== 2'b10 || mSign !== 1'b0) begin errors++; $display("[TB] FAIL fetch.attr got we=%0h size=%0h sign=%0h want 0/2/0", mWe, mSize, mSign); end
    checks++; if (busy !== 1'b1 || ifGnt !== 1'b0) begin errors++; $display("[TB] FAIL fetch.busy got busy=%0h gnt=%0h want 1/0", busy, ifGnt); end
    nextCycle();
    mRdy = 0;
    #1;
    checks++; if (ifValid !== 1'b1)   begin errors++; $display("[TB] FAIL fetch.valid got %0h want 1", ifValid); end
    checks++; if (ifRdata !== 32'h13) begin errors++; $display("[TB] FAIL fetch.rdata got %0h want 13", ifRdata); end
    checks++; if (mReq !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch.done got mReq=%0h busy=%0h want 0/0", mReq, busy); end
    nextCycle();
    #1;
    checks++; if (ifValid !== 1'b0 || ifRdata !== 32'h13) begin errors++; $display("[TB] FAIL fetch.after got valid=%0h rdata=%0h want 0/13", ifValid, ifRdata); end
  endtask

  task test_starvation;
    logic expD;
    doReset();
    ifReq = 1; ifAddr = 32'h200; dReq = 1; dWe = 0; dAddr = 32'h300; dSize = 2;
    mRdy = 1; mRdata = 32'h55;
    for (int g = 0; g < 11; g++) begin
      expD = ((g % (STARVE + 1)) != STARVE);
      #1;
      checks++; if (dGnt !== expD || ifGnt !== !expD) begin errors++; $display("[TB] FAIL starve.grant%0d got d=%0h if=%0h want d=%0h", g, dGnt, ifGnt, expD); end
      nextCycle();
      #1;
      checks++; if (ifGnt !== 1'b0 || dGnt !== 1'b0) begin errors++; $display("[TB] FAIL starve.busygnt%0d got %0h/%0h want 0/0", g, ifGnt, dGnt); end
      nextCycle();
    end
    applyStimulus();
  endtask

  task test_write_hold;
    doReset();
    dReq = 1; dWe = 0; dAddr = 32'h20; dSize = 2;
    nextCycle();
    dReq = 0; mRdy = 1; mRdata = 32'hCAFEF00D;
    nextCycle();
    mRdy = 0;
    #1;
    checks++; if (dValid !== 1'b1 || dRdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL write.prime got valid=%0h rdata=%0h want 1/cafef00d", dValid, dRdata); end
    dReq = 1; dWe = 1; dAddr = 32'h11000040; dWdata = 32'hDEADBEEF; dSize = 2; dSign = 0;
    #1;
    checks++; if (dGnt !== 1'b1) begin errors++; $display("[TB] FAIL write.gnt got %0h want 1", dGnt); end
    nextCycle();
    dReq = 0; dAddr = $urandom; dWdata = $urandom; dSize = 0; dWe = 0; mRdata = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mRdy = 1;
      #1;
      checks++;
      if (mReq !== 1'b1 || mWe !== 1'b1 || mAddr !== 32'h11000040 || mWdata !== 32'hDEADBEEF || mSize !== 2'd2) begin
        errors++;
        $display("[TB] FAIL write.hold%0d got req=%0h we=%0h addr=%0h wdata=%0h size=%0h want 1/1/11000040/deadbeef/2", k, mReq, mWe, mAddr, mWdata, mSize);
      end
      nextCycle();
    end
    mRdy = 0;
    #1;
    checks++; if (dValid !== 1'b1) begin errors++; $display("[TB] FAIL write.valid got %0h want 1", dValid); end
    checks++; if (dRdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL write.rdata got %0h want cafef00d", dRdata); end
    checks++; if (mReq !== 1'b0) begin errors++; $display("[TB] FAIL write.mReq got %0h want 0", mReq); end
    nextCycle();
    #1;
    checks++; if (dValid !== 1'b0) begin errors++; $display("[TB] FAIL write.pulse got %0h want 0", dValid); end
  endtask

  task test_reset_midflight;
    doReset();
    dReq = 1; dWe = 0; dAddr = 32'h40; dSize = 2;
    nextCycle();
    dReq = 0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst.busy got %0h want 1", busy); end
    rstN = 0;
    nextCycle();
    rstN = 1; mRdy = 1; mRdata = 32'hAAAA5555;
    #1;
    checks++; if (busy !== 1'b0 || mReq !== 1'b0 || mWe !== 1'b0) begin errors++; $display("[TB] FAIL midrst.state got busy=%0h req=%0h we=%0h want 0/0/0", busy, mReq, mWe); end
    checks++; if (mAddr !== 32'h0 || mWdata !== 32'h0 || err !== 1'b0) begin errors++; $display("[TB] FAIL midrst.data got addr=%0h wdata=%0h err=%0h want 0/0/0", mAddr, mWdata, err); end
    nextCycle();
    mRdy = 0;
    #1;
    checks++; if (dValid !== 1'b0 || busy !== 1'b0 || dRdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst.late got valid=%0h busy=%0h rdata=%0h want 0/0/0", dValid, busy, dRdata); end
  endtask

  task test_idle_rdy;
    doReset();
    mRdy = 1; mRdata = 32'h77;
    nextCycle();
    mRdy = 0;
    #1;
    checks++; if (ifValid !== 1'b0 || dValid !== 1'b0) begin errors++; $display("[TB] FAIL idlerdy.valid got %0h/%0h want 0/0", ifValid, dValid); end
    checks++; if (busy !== 1'b0 || mReq !== 1'b0) begin errors++; $display("[TB] FAIL idlerdy.state got busy=%0h req=%0h want 0/0", busy, mReq); end
    checks++; if (ifRdata !== 32'h0 || dRdata !== 32'h0) begin errors++; $display("[TB] FAIL idlerdy.rdata got %0h/%0h want 0/0", ifRdata, dRdata); end
  endtask

  task test_timeout;
    int sawEnd;
    doReset();
    dReq = 1; dWe = 0; dAddr = 32'h80; dSize = 2;
    nextCycle();
    dReq = 0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TCYC; k++) begin
      #1;
      checks++; if (busy !== 1'b1 || mReq !== 1'b1) begin errors++; $display("[TB] FAIL timeout.wait%0d got busy=%0h req=%0h want 1/1", k, busy, mReq); end
      nextCycle();
    end
    #1;
    checks++; if (mReq !== 1'b0 || dValid !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL timeout.abort got req=%0h valid=%0h err=%0h want 0/1/1", mReq, dValid, err); end
    nextCycle();
    #1;
    checks++; if (dValid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout.pulse got valid=%0h err=%0h busy=%0h want 0/0/0", dValid, err, busy); end
`else
    sawEnd = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (busy !== 1'b1 || mReq !== 1'b1 || dValid !== 1'b0 || err !== 1'b0) sawEnd++;
      nextCycle();
    end
    checks++; if (sawEnd != 0) begin errors++; $display("[TB] FAIL nowait.hold got %0d bad cycles want 0", sawEnd); end
    mRdy = 1; mRdata = 32'h99;
    nextCycle();
    mRdy = 0;
    #1;
    checks++; if (dValid !== 1'b1 || dRdata !== 32'h99) begin errors++; $display("[TB] FAIL nowait.done got valid=%0h rdata=%0h want 1/99", dValid, dRdata); end
`endif
  endtask

  // Reference model: owner of the port (0 none, 1 fetch, 2 data) and its transaction.
  int          mOwner, mStarve, mWait;
  logic        eIfValid, eDValid, eErr, eMreq, eWe, eSign;
  logic [31:0] eIfRdata, eDRdata, eAddr, eWdata;
  logic [1:0]  eSize;

  task test_random;
    logic eD, eI;
    doReset();
    mOwner = 0; mStarve = 0; mWait = 0;
    eIfValid = 0; eDValid = 0; eErr = 0; eMreq = 0; eWe = 0; eSign = 0;
    eIfRdata = 0; eDRdata = 0; eAddr = 0; eWdata = 0; eSize = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ifReq && ($urandom % 4) == 0) begin ifReq = 1; ifAddr = $urandom; end
      if (!dReq && ($urandom % 3) == 0) begin
        dReq = 1; dWe = 1'($urandom % 2); dAddr = $urandom; dWdata = $urandom;
        dSize = 2'($urandom % 4); dSign = 1'($urandom % 2);
      end
      mRdy = (($urandom % 3) != 0); mRdata = $urandom;
      #1;
      eD = (mOwner == 0) && dReq && !(ifReq && mStarve == STARVE);
      eI = (mOwner == 0) && ifReq && !eD;
      checks++; if (dGnt !== eD || ifGnt !== eI) begin errors++; $display("[TB] FAIL rnd.gnt@%0d got d=%0h if=%0h want d=%0h if=%0h", cyc, dGnt, ifGnt, eD, eI); end
      checks++; if (busy !== (mOwner != 0) || mReq !== eMreq) begin errors++; $display("[TB] FAIL rnd.busy@%0d got busy=%0h req=%0h want %0h/%0h", cyc, busy, mReq, mOwner != 0, eMreq); end
      checks++; if (ifValid !== eIfValid || dValid !== eDValid || err !== eErr) begin errors++; $display("[TB] FAIL rnd.valid@%0d got %0h/%0h/%0h want %0h/%0h/%0h", cyc, ifValid, dValid, err, eIfValid, eDValid, eErr); end
      checks++; if (ifRdata !== eIfRdata || dRdata !== eDRdata) begin errors++; $display("[TB] FAIL rnd.rdata@%0d got %0h/%0h want %0h/%0h", cyc, ifRdata, dRdata, eIfRdata, eDRdata); end
      if (eMreq) begin
        checks++;
        if (mAddr !== eAddr || mWe !== eWe || mSize !== eSize || mSign !== eSign || (eWe && mWdata !== eWdata)) begin
          errors++;
          $display("[TB] FAIL rnd.port@%0d got a=%0h we=%0h sz=%0h sg=%0h wd=%0h want %0h/%0h/%0h/%0h/%0h", cyc, mAddr, mWe, mSize, mSign, mWdata, eAddr, eWe, eSize, eSign, eWdata);
        end
      end
      @(posedge clk);
      eIfValid = 0; eDValid = 0; eErr = 0;
      if (eD) begin
        mOwner = 2; eMreq = 1; mWait = 0;
        eAddr = dAddr; eWdata = dWdata; eWe = dWe; eSize = dSize; eSign = dSign;
        if (ifReq && mStarve < STARVE) mStarve++;
      end else if (eI) begin
        mOwner = 1; eMreq = 1; mWait = 0; mStarve = 0;
        eAddr = ifAddr; eWe = 0; eSize = 2'b10; eSign = 0;
      end else if (mOwner != 0 && mRdy) begin
        if (mOwner == 1) begin eIfValid = 1; if (!eWe) eIfRdata = mRdata; end
        else             begin eDValid = 1;  if (!eWe) eDRdata = mRdata; end
        mOwner = 0; eMreq = 0;
`ifdef ARB_TIMEOUT_EN
      end else if (mOwner != 0) begin
        if (mWait == TCYC - 1) begin
          if (mOwner == 1) eIfValid = 1; else eDValid = 1;
          eErr = 1; mOwner = 0; eMreq = 0;
        end else mWait++;
`endif
      end
      @(negedge clk);
      if (eI) ifReq = 0;
      if (eD) dReq = 0;
    end
    applyStimulus();
  endtask

  initial begin
    rstN = 0;
    applyStimulus();
    @(negedge clk);
    test_reset();
    test_fetch_read();
    test_starvation();
    test_write_hold();
    test_reset_midflight();
    test_idle_rdy();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
